addsub_sched: RTL and testbench
===============================

# addsub_sched

Round-robin scheduler that time-shares one combinational `addsub` instance between `N` requesters. It accepts operand/opcode requests over per-requester valid/ready channels, drives the shared `addsub` operands from registers, captures `S`/`COUT`, and returns them tagged with the requester ID on a single response channel. It sits between the requesting datapath blocks and the single `addsub` in the arithmetic component group.

## Interface
- `WIDTH`, default 4: operand and result width; must match the attached `addsub`.
- `N`, default 2: number of requesters, 2..4.
- `IDW`, default `$clog2(N)`: width of the requester ID.
- `CLK`, input, 1: sole clock; all state updates on the rising edge.
- `RST_N`, input, 1: asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `REQ_VALID`, input, N: per-requester request valid.
- `REQ_READY`, output, N: per-requester accept; one-hot or zero.
- `REQ_A`, input, N*WIDTH: per-requester operand A; requester i occupies slice [i*WIDTH +: WIDTH].
- `REQ_B`, input, N*WIDTH: per-requester operand B; same packing as `REQ_A`.
- `REQ_SUB`, input, N: per-requester opcode; 0 = A+B, 1 = A-B.
- `AS_A`, output, WIDTH: operand A to the shared `addsub`.
- `AS_B`, output, WIDTH: operand B to the shared `addsub`.
- `AS_SUB`, output, 1: SUB select to the shared `addsub`.
- `AS_S`, input, WIDTH: `S` from the shared `addsub`.
- `AS_COUT`, input, 1: `COUT` from the shared `addsub`.
- `RSP_VALID`, output, 1: response valid.
- `RSP_READY`, input, 1: consumer accepts the response.
- `RSP_ID`, output, IDW: index of the requester that owns the response.
- `RSP_S`, output, WIDTH: captured sum/difference.
- `RSP_COUT`, output, 1: captured carry out. For subtract, 1 means no borrow.

## Operation
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- **IDLE**
  - If any `REQ_VALID` is high, pick winner g by round-robin: search from `PTR` upward with wrap-around, first valid wins.
  - Assert `REQ_READY[g]` combinationally in the same cycle. The handshake completes that cycle.
  - At the clock edge: latch `REQ_A[g]`, `REQ_B[g]` and `REQ_SUB[g]` into the operand registers feeding `AS_A`, `AS_B` and `AS_SUB`. Latch g into the ID register. Set `PTR` to (g+1) mod N. Go to EXEC.
  - If no request is valid, `REQ_READY` is 0 and all state holds.
- **EXEC**
  - `REQ_READY` is all zero.
  - The operand registers are stable for the full cycle.
  - At the edge: capture `AS_S` into `RSP_S` and `AS_COUT` into `RSP_COUT`, set `RSP_VALID`, go to RESP.
- **RESP**
  - `RSP_VALID` is 1. `RSP_ID`, `RSP_S` and `RSP_COUT` are held stable until the handshake.
  - When `RSP_READY` is 1: clear `RSP_VALID` at the edge and go to IDLE.
  - `REQ_READY` stays 0 throughout RESP (backpressure).
- `REQ_READY` is never asserted while `RST_N` is low, and is never asserted to a requester whose `REQ_VALID` is 0.
- Arithmetic is entirely the attached `addsub`. No widening and no overflow flagging. Results wrap modulo 2^WIDTH.
- Requesters are unconstrained: deasserting `REQ_VALID` without a handshake is legal and simply drops out of arbitration.

## Timing
- Reset values: FSM = IDLE, `PTR` = 0, `AS_A` = 0, `AS_B` = 0, `AS_SUB` = 0, `RSP_VALID` = 0, `RSP_ID` = 0, `RSP_S` = 0, `RSP_COUT` = 0, `REQ_READY` = 0.
- Latency: request handshake in cycle t, operands on `AS_*` from t+1, `RSP_VALID` high from t+2.
- Minimum issue interval is 3 cycles, reached when `RSP_READY` is already high in RESP.
- Reset asserted mid-operation (EXEC or RESP): everything returns to reset values immediately. The in-flight response is discarded and never presented.
- Simultaneous requests: exactly one grant per IDLE cycle. With all N requesters continuously valid, each is served once every N transactions.
- `RSP_READY` high outside RESP has no effect.

## Test plan
- Reset, then requester 0 presents A=10, B=3, SUB=0 -> `REQ_READY[0]` high that cycle; two cycles later `RSP_VALID`=1, `RSP_ID`=0, `RSP_S`=13, `RSP_COUT`=0.
- Requester 1 presents A=10, B=3, SUB=1 -> `RSP_S`=7, `RSP_COUT`=1, `RSP_ID`=1. Then A=9, B=1 with SUB=0 -> `RSP_S`=10; with SUB=1 -> `RSP_S`=8.
- Wrap-around: A=15, B=1, SUB=0 -> `RSP_S`=0, `RSP_COUT`=1. Borrow: A=3, B=10, SUB=1 -> `RSP_S`=9, `RSP_COUT`=0.
- Both requesters valid continuously, `RSP_READY`=1 -> grants alternate 0,1,0,1 starting from 0; each response appears every 3 cycles with the correct ID and result.
- Hold `RSP_READY`=0 for 5 cycles in RESP while both requesters are valid -> `RSP_*` stable, `REQ_READY`=0 throughout; release -> one handshake, then IDLE grants the next requester.
- Drop `RST_N` during EXEC -> `RSP_VALID` stays 0, all outputs are at reset values the same cycle, `PTR`=0 so requester 0 wins first after release.

Source files
------------

// File: rtl/addsub_sched_if.sv
// Bundles the request channels, the shared addsub operand/result wires and
// the tagged response channel of the addsub scheduler.
interface addsub_sched_if #(
    parameter int WIDTH = 4,
    parameter int N     = 2,
    parameter int IDW   = $clog2(N)
) ();
    logic [N-1:0]       REQ_VALID;
    logic [N-1:0]       REQ_READY;
    logic [N*WIDTH-1:0] REQ_A;
    logic [N*WIDTH-1:0] REQ_B;
    logic [N-1:0]       REQ_SUB;

    logic [WIDTH-1:0]   AS_A;
    logic [WIDTH-1:0]   AS_B;
    logic               AS_SUB;
    logic [WIDTH-1:0]   AS_S;
    logic               AS_COUT;

    logic               RSP_VALID;
    logic               RSP_READY;
    logic [IDW-1:0]     RSP_ID;
    logic [WIDTH-1:0]   RSP_S;
    logic               RSP_COUT;

    // Scheduler side
    modport master (
        input  REQ_VALID, REQ_A, REQ_B, REQ_SUB, AS_S, AS_COUT, RSP_READY,
        output REQ_READY, AS_A, AS_B, AS_SUB, RSP_VALID, RSP_ID, RSP_S, RSP_COUT
    );

    // Requesters, consumer and the shared addsub
    modport slave (
        output REQ_VALID, REQ_A, REQ_B, REQ_SUB, AS_S, AS_COUT, RSP_READY,
        input  REQ_READY, AS_A, AS_B, AS_SUB, RSP_VALID, RSP_ID, RSP_S, RSP_COUT
    );
endinterface

// File: rtl/addsub_sched.sv
// Round-robin scheduler sharing one combinational addsub between N requesters;
// one transaction at a time: grant (IDLE) -> compute (EXEC) -> respond (RESP).
module addsub_sched #(
    parameter int WIDTH = 4,
    parameter int N     = 2,
    parameter int IDW   = $clog2(N)
) (
    input  logic           CLK,
    input  logic           RST_N,
    addsub_sched_if.master bus
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t           state_reg, state_next;
    logic [IDW-1:0]   ptr_reg, ptr_next;
    logic [IDW-1:0]   id_reg, id_next;
    logic [WIDTH-1:0] a_reg, a_next;
    logic [WIDTH-1:0] b_reg, b_next;
    logic             sub_reg, sub_next;
    logic [WIDTH-1:0] s_reg, s_next;
    logic             cout_reg, cout_next;
    logic             rsp_valid_reg, rsp_valid_next;

    logic [WIDTH-1:0] req_a [N];
    logic [WIDTH-1:0] req_b [N];

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_unpack
            assign req_a[gi] = bus.REQ_A[gi*WIDTH +: WIDTH];
            assign req_b[gi] = bus.REQ_B[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // Search upward from ptr_reg with wrap-around; first valid requester wins.
    logic           grant_found;
    logic [IDW-1:0] grant_id;
    logic [IDW:0]   rr_sum;
    logic [IDW-1:0] rr_idx;

    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        rr_sum      = '0;
        rr_idx      = '0;
        for (int k = 0; k < N; k++) begin
            rr_sum = {1'b0, ptr_reg} + (IDW+1)'(k);
            if (rr_sum >= (IDW+1)'(N))
                rr_sum = rr_sum - (IDW+1)'(N);
            rr_idx = rr_sum[IDW-1:0];
            if (!grant_found && bus.REQ_VALID[rr_idx]) begin
                grant_found = 1'b1;
                grant_id    = rr_idx;
            end
        end
    end

    always_comb begin
        state_next     = state_reg;
        ptr_next       = ptr_reg;
        id_next        = id_reg;
        a_next         = a_reg;
        b_next         = b_reg;
        sub_next       = sub_reg;
        s_next         = s_reg;
        cout_next      = cout_reg;
        rsp_valid_next = rsp_valid_reg;
        bus.REQ_READY  = '0;
        case (state_reg)
            IDLE: begin
                if (grant_found) begin
                    // Gated so no grant is ever shown while reset is held.
                    bus.REQ_READY[grant_id] = RST_N;
                    a_next     = req_a[grant_id];
                    b_next     = req_b[grant_id];
                    sub_next   = bus.REQ_SUB[grant_id];
                    id_next    = grant_id;
                    ptr_next   = (grant_id == IDW'(N-1)) ? '0 : grant_id + 1'b1;
                    state_next = EXEC;
                end
            end
            EXEC: begin
                s_next         = bus.AS_S;
                cout_next      = bus.AS_COUT;
                rsp_valid_next = 1'b1;
                state_next     = RESP;
            end
            RESP: begin
                if (bus.RSP_READY) begin
                    rsp_valid_next = 1'b0;
                    state_next     = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_reg     <= IDLE;
            ptr_reg       <= '0;
            id_reg        <= '0;
            a_reg         <= '0;
            b_reg         <= '0;
            sub_reg       <= 1'b0;
            s_reg         <= '0;
            cout_reg      <= 1'b0;
            rsp_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            ptr_reg       <= ptr_next;
            id_reg        <= id_next;
            a_reg         <= a_next;
            b_reg         <= b_next;
            sub_reg       <= sub_next;
            s_reg         <= s_next;
            cout_reg      <= cout_next;
            rsp_valid_reg <= rsp_valid_next;
        end
    end

    assign bus.AS_A      = a_reg;
    assign bus.AS_B      = b_reg;
    assign bus.AS_SUB    = sub_reg;
    assign bus.RSP_VALID = rsp_valid_reg;
    assign bus.RSP_ID    = id_reg;
    assign bus.RSP_S     = s_reg;
    assign bus.RSP_COUT  = cout_reg;
endmodule

// File: tb/tb_addsub_sched.sv
// Directed bench for addsub_sched with a behavioural 4-bit addsub attached.
module tb_addsub_sched;
    localparam int WIDTH = 4;
    localparam int N     = 2;

    logic CLK = 1'b0;
    logic RST_N;
    int   vectors = 0;
    int   miscompares = 0;

    addsub_sched_if #(.WIDTH(WIDTH), .N(N)) bus ();

    addsub_sched #(.WIDTH(WIDTH), .N(N)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    // Shared addsub: A + (B or ~B) + SUB, COUT is the carry out of the top bit.
    logic [WIDTH:0] as_sum;
    assign as_sum      = {1'b0, bus.AS_A} + {1'b0, (bus.AS_SUB ? ~bus.AS_B : bus.AS_B)} + {{WIDTH{1'b0}}, bus.AS_SUB};
    assign bus.AS_S    = as_sum[WIDTH-1:0];
    assign bus.AS_COUT = as_sum[WIDTH];

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_req(input int id, input logic [3:0] a, input logic [3:0] b, input logic sub,
                          input logic [3:0] es, input logic ec);
        logic [1:0] exp_rdy;
        exp_rdy           = '0;
        exp_rdy[id]       = 1'b1;
        bus.REQ_VALID     = '0;
        bus.REQ_VALID[id] = 1'b1;
        bus.REQ_A[id*4 +: 4] = a;
        bus.REQ_B[id*4 +: 4] = b;
        bus.REQ_SUB[id]   = sub;
        bus.RSP_READY     = 1'b0;
        #1;
        chk("req_ready_grant", 32'(bus.REQ_READY), 32'(exp_rdy));
        tick();
        bus.REQ_VALID = '0;
        #1;
        chk("exec_as_a", 32'(bus.AS_A), 32'(a));
        chk("exec_as_b", 32'(bus.AS_B), 32'(b));
        chk("exec_as_sub", 32'(bus.AS_SUB), 32'(sub));
        chk("exec_rsp_valid", 32'(bus.RSP_VALID), 32'd0);
        chk("exec_req_ready", 32'(bus.REQ_READY), 32'd0);
        tick();
        chk("rsp_valid", 32'(bus.RSP_VALID), 32'd1);
        chk("rsp_id", 32'(bus.RSP_ID), 32'(id));
        chk("rsp_s", 32'(bus.RSP_S), 32'(es));
        chk("rsp_cout", 32'(bus.RSP_COUT), 32'(ec));
        bus.RSP_READY = 1'b1;
        tick();
        bus.RSP_READY = 1'b0;
        chk("rsp_cleared", 32'(bus.RSP_VALID), 32'd0);
        $display("req id=%0d a=%0d b=%0d sub=%0d -> s=%0d cout=%0d", id, a, b, sub, bus.RSP_S, bus.RSP_COUT);
    endtask

    logic [3:0] rr_as_a [2] = '{4'd1, 4'd7};
    logic [3:0] rr_s    [2] = '{4'd3, 4'd5};
    logic       rr_c    [2] = '{1'b0, 1'b1};

    initial begin
        RST_N         = 1'b0;
        bus.REQ_VALID = 2'b11;
        bus.REQ_A     = '0;
        bus.REQ_B     = '0;
        bus.REQ_SUB   = '0;
        bus.RSP_READY = 1'b0;
        tick();
        tick();
        // Reset state, with both requesters valid during reset
        chk("rst_req_ready", 32'(bus.REQ_READY), 32'd0);
        chk("rst_rsp_valid", 32'(bus.RSP_VALID), 32'd0);
        chk("rst_as_a", 32'(bus.AS_A), 32'd0);
        chk("rst_as_b", 32'(bus.AS_B), 32'd0);
        chk("rst_as_sub", 32'(bus.AS_SUB), 32'd0);
        chk("rst_rsp_id", 32'(bus.RSP_ID), 32'd0);
        chk("rst_rsp_s", 32'(bus.RSP_S), 32'd0);
        chk("rst_rsp_cout", 32'(bus.RSP_COUT), 32'd0);
        bus.REQ_VALID = '0;
        RST_N = 1'b1;
        tick();

        do_req(0, 4'd10, 4'd3, 1'b0, 4'd13, 1'b0);
        do_req(1, 4'd10, 4'd3, 1'b1, 4'd7,  1'b1);
        do_req(1, 4'd9,  4'd1, 1'b0, 4'd10, 1'b0);
        do_req(1, 4'd9,  4'd1, 1'b1, 4'd8,  1'b1);
        do_req(0, 4'd15, 4'd1, 1'b0, 4'd0,  1'b1);
        do_req(1, 4'd3,  4'd10, 1'b1, 4'd9, 1'b0);

        // Both requesters continuously valid, consumer always ready
        bus.REQ_A     = {4'd7, 4'd1};
        bus.REQ_B     = {4'd2, 4'd2};
        bus.REQ_SUB   = 2'b10;
        bus.REQ_VALID = 2'b11;
        bus.RSP_READY = 1'b1;
        #1;
        for (int t = 0; t < 4; t++) begin
            chk("rr_grant", 32'(bus.REQ_READY), 32'(1 << (t % 2)));
            tick();
            chk("rr_exec_ready", 32'(bus.REQ_READY), 32'd0);
            chk("rr_as_a", 32'(bus.AS_A), 32'(rr_as_a[t % 2]));
            tick();
            chk("rr_rsp_valid", 32'(bus.RSP_VALID), 32'd1);
            chk("rr_rsp_id", 32'(bus.RSP_ID), 32'(t % 2));
            chk("rr_rsp_s", 32'(bus.RSP_S), 32'(rr_s[t % 2]));
            chk("rr_rsp_cout", 32'(bus.RSP_COUT), 32'(rr_c[t % 2]));
            $display("rr txn %0d id=%0d s=%0d cout=%0d", t, bus.RSP_ID, bus.RSP_S, bus.RSP_COUT);
            tick();
        end

        // Backpressure: response held for 5 cycles
        bus.RSP_READY = 1'b0;
        chk("bp_grant", 32'(bus.REQ_READY), 32'd1);
        tick();
        tick();
        for (int t = 0; t < 5; t++) begin
            chk("bp_rsp_valid", 32'(bus.RSP_VALID), 32'd1);
            chk("bp_rsp_id", 32'(bus.RSP_ID), 32'd0);
            chk("bp_rsp_s", 32'(bus.RSP_S), 32'd3);
            chk("bp_req_ready", 32'(bus.REQ_READY), 32'd0);
            tick();
        end
        bus.RSP_READY = 1'b1;
        tick();
        bus.RSP_READY = 1'b0;
        #1;
        chk("bp_next_grant", 32'(bus.REQ_READY), 32'd2);
        $display("backpressure released, next grant=%0b", bus.REQ_READY);
        tick();
        chk("pre_rst_as_a", 32'(bus.AS_A), 32'd7);

        // Reset during EXEC
        RST_N = 1'b0;
        #1;
        chk("mid_rst_rsp_valid", 32'(bus.RSP_VALID), 32'd0);
        chk("mid_rst_as_a", 32'(bus.AS_A), 32'd0);
        chk("mid_rst_as_b", 32'(bus.AS_B), 32'd0);
        chk("mid_rst_as_sub", 32'(bus.AS_SUB), 32'd0);
        chk("mid_rst_rsp_id", 32'(bus.RSP_ID), 32'd0);
        chk("mid_rst_req_ready", 32'(bus.REQ_READY), 32'd0);
        tick();
        tick();
        chk("mid_rst_hold_valid", 32'(bus.RSP_VALID), 32'd0);
        RST_N = 1'b1;
        #1;
        chk("post_rst_grant", 32'(bus.REQ_READY), 32'd1);
        tick();
        tick();
        chk("post_rst_rsp_valid", 32'(bus.RSP_VALID), 32'd1);
        chk("post_rst_rsp_id", 32'(bus.RSP_ID), 32'd0);
        chk("post_rst_rsp_s", 32'(bus.RSP_S), 32'd3);
        $display("post-reset txn id=%0d s=%0d", bus.RSP_ID, bus.RSP_S);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
